// File: rtl/cpu_pkg.sv
// Shared CPU-side constants, the response record, and the ROM address check
// used by the instruction ROM port arbiter.
package cpu_pkg;

    localparam int ROM_WORDS = 32;
    localparam int ADDR_W    = 31;
    localparam int WORD_AW   = 29;

    typedef struct packed {
        logic        if_v;
        logic        dm_v;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    // A byte address is usable when word aligned and inside the populated ROM.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a, input int unsigned words);
        logic [31:0] idx;
        idx = {3'b000, a[ADDR_W-1:ADDR_W-WORD_AW]};
        return (a[1:0] == 2'b00) && (idx < words);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up counter that sticks at all-ones; synchronous clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            value <= '0;
        else if (clr)
            value <= '0;
        else if (inc && (value != '1))
            value <= value + 1'b1;
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the instruction ROM read port between fetch and data-side loads.
// Fetch wins by default; a starvation counter periodically forces a DM grant.
module rom_port_arbiter
    import cpu_pkg::*;
#(
    parameter int ROM_WORDS    = cpu_pkg::ROM_WORDS,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_req,
    input  logic [30:0]      if_addr,
    output logic             if_gnt,
    output logic             if_rvalid,
    output logic [31:0]      if_rdata,
    input  logic             dm_req,
    input  logic [30:0]      dm_addr,
    output logic             dm_gnt,
    output logic             dm_rvalid,
    output logic [31:0]      dm_rdata,
    output logic [30:0]      rom_addr,
    input  logic [31:0]      rom_data,
    output logic             acc_err,
    output logic [CNT_W-1:0] if_cnt,
    output logic [CNT_W-1:0] dm_stall_cnt
);

    logic [3:0] wait_cnt;
    logic       dm_deny;
    logic       any_gnt;
    logic       ok;
    rsp_t       rsp;

    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (dm_req && (wait_cnt >= 4'(STARVE_LIMIT)))
            dm_gnt = 1'b1;
        else if (if_req)
            if_gnt = 1'b1;
        else if (dm_req)
            dm_gnt = 1'b1;
    end

    assign rom_addr = dm_gnt ? dm_addr : if_addr;
    assign dm_deny  = dm_req & ~dm_gnt;
    assign any_gnt  = if_gnt | dm_gnt;
    assign ok       = addr_ok(rom_addr, ROM_WORDS);

    // Data is only reloaded on a grant; the strobes qualify it downstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp <= '0;
        end else begin
            rsp.if_v <= if_gnt;
            rsp.dm_v <= dm_gnt;
            rsp.err  <= any_gnt & ~ok;
            if (any_gnt)
                rsp.data <= ok ? rom_data : 32'h0;
        end
    end

    assign if_rvalid = rsp.if_v;
    assign dm_rvalid = rsp.dm_v;
    assign acc_err   = rsp.err;
    assign if_rdata  = rsp.data;
    assign dm_rdata  = rsp.data;

    sat_counter #(.W(4)) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (dm_deny),
        .clr   (~dm_deny),
        .value (wait_cnt)
    );

    sat_counter #(.W(CNT_W)) u_if_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (if_gnt),
        .clr   (1'b0),
        .value (if_cnt)
    );

    sat_counter #(.W(CNT_W)) u_dm_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (dm_deny),
        .clr   (1'b0),
        .value (dm_stall_cnt)
    );

endmodule
